// File: rtl/uart_rx_drain_ctrl.sv
// UART RX drain controller: pulls bytes from the RX FIFO onto a valid/ready
// stream, with stream/burst drain policy, flush and sticky status interrupts.
module uart_rx_drain_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       mode,
    input  logic       flush,
    input  logic       rx_stb,
    input  logic [7:0] fifo_dout,
    input  logic       fifo_empty,
    input  logic       fifo_thre,
    input  logic       fifo_overrun,
    input  logic       fifo_underrun,
    output logic       fifo_pop,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [3:0] status,
    input  logic [3:0] status_clr,
    input  logic [3:0] irq_mask,
    output logic       irq,
    output logic       busy
);

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    state_e     state_q, state_d;
    logic       m_valid_q, m_valid_d;
    logic [7:0] m_data_q, m_data_d;
    logic [3:0] status_q, status_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       thre_q, thre_d;
    logic       tmo_q, tmo_d;
    logic       tmo_hit;
    logic       drain_pop;
    logic       flush_entry;
    logic [3:0] status_set;

    assign tmo_hit = (cnt_q == TMO);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT: begin
                if (flush) begin
                    state_d = FLUSH;
                end else if (en && !fifo_empty &&
                             (!mode || fifo_thre || tmo_hit)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (flush) begin
                    state_d = FLUSH;
                end else if (!en || fifo_empty) begin
                    state_d = WAIT;
                end
            end
            FLUSH: begin
                if (fifo_empty) begin
                    state_d = WAIT;
                end
            end
            default: state_d = WAIT;
        endcase
    end

    // State-decoded outputs; pops are gated by empty so no underrun is caused
    always_comb begin
        fifo_pop = 1'b0;
        busy     = 1'b1;
        unique case (state_q)
            WAIT:  busy = 1'b0;
            DRAIN: fifo_pop = !fifo_empty && en && (!m_valid_q || m_ready);
            FLUSH: fifo_pop = !fifo_empty;
            default: busy = 1'b0;
        endcase
    end

    assign drain_pop   = fifo_pop && (state_q == DRAIN);
    assign flush_entry = (state_d == FLUSH) && (state_q != FLUSH);

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        if (flush_entry) begin
            m_valid_d = 1'b0;
        end else if (drain_pop) begin
            m_valid_d = 1'b1;
            m_data_d  = fifo_dout;
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (rx_stb || fifo_pop || fifo_empty || (state_q != WAIT)) begin
            cnt_d = '0;
        end else if (!tmo_hit) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Timeout flag is raised once per arrival at the saturation value
    always_comb begin
        thre_d     = fifo_thre;
        tmo_d      = tmo_hit;
        status_set = {fifo_thre && !thre_q, tmo_hit && !tmo_q,
                      fifo_underrun, fifo_overrun};
        status_d   = (status_q & ~status_clr) | status_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= 8'h00;
            status_q  <= 4'h0;
            cnt_q     <= '0;
            thre_q    <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            status_q  <= status_d;
            cnt_q     <= cnt_d;
            thre_q    <= thre_d;
            tmo_q     <= tmo_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign status  = status_q;
    assign irq     = |(status_q & irq_mask);

endmodule

// File: tb/tb_uart_rx_drain_ctrl.sv
// Directed bench for uart_rx_drain_ctrl with a small behavioural FIFO
// standing in for the RX FIFO (threshold level 4).
module tb_uart_rx_drain_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, mode, flush, rx_stb;
    logic [7:0] rx_byte;
    logic [7:0] fifo_dout;
    logic       fifo_empty, fifo_thre, fifo_overrun, fifo_underrun;
    logic       fifo_pop;
    logic [7:0] m_data;
    logic       m_valid, m_ready;
    logic [3:0] status, status_clr, irq_mask;
    logic       irq, busy;

    logic [7:0] q[$];
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_rx_drain_ctrl #(.TIMEOUT(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .flush(flush),
        .rx_stb(rx_stb), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_thre(fifo_thre), .fifo_overrun(fifo_overrun),
        .fifo_underrun(fifo_underrun), .fifo_pop(fifo_pop),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .status(status), .status_clr(status_clr), .irq_mask(irq_mask),
        .irq(irq), .busy(busy)
    );

    typedef struct {
        logic       stb;
        logic [7:0] b;
        logic       ovr;
        logic       und;
        logic [3:0] clr;
        logic [3:0] mask;
        logic       pop;
        logic       vld;
        logic [7:0] dat;
        logic [3:0] st;
        logic       irq;
        logic       bsy;
    } vec_t;

    vec_t tv[14];

    function automatic vec_t mk(logic stb, logic [7:0] b, logic ovr,
                                logic und, logic [3:0] clr, logic [3:0] mask,
                                logic pop, logic vld, logic [7:0] dat,
                                logic [3:0] st, logic ir, logic bsy);
        vec_t v;
        v.stb = stb; v.b = b; v.ovr = ovr; v.und = und;
        v.clr = clr; v.mask = mask; v.pop = pop; v.vld = vld;
        v.dat = dat; v.st = st; v.irq = ir; v.bsy = bsy;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fifo_set();
        fifo_empty = (q.size() == 0);
        fifo_dout  = fifo_empty ? 8'h00 : q[0];
        fifo_thre  = (q.size() >= 4);
    endtask

    task automatic idle();
        rx_stb = 1'b0; rx_byte = 8'h00; flush = 1'b0;
        fifo_overrun = 1'b0; fifo_underrun = 1'b0; status_clr = 4'h0;
    endtask

    // Settle to the negedge for checking
    task automatic mid();
        @(negedge clk);
    endtask

    // Finish the cycle: apply FIFO push/pop at the edge, then clear pulses
    task automatic tick();
        logic p, s;
        logic [7:0] b;
        p = fifo_pop; s = rx_stb; b = rx_byte;
        @(posedge clk);
        #1;
        if (p && q.size() > 0) void'(q.pop_front());
        if (s) q.push_back(b);
        fifo_set();
        idle();
    endtask

    task automatic push(logic [7:0] b);
        rx_stb = 1'b1; rx_byte = b;
    endtask

    initial begin
        logic [7:0] got[$];
        int npop;

        rst = 1'b1; en = 1'b1; mode = 1'b0; m_ready = 1'b1; irq_mask = 4'h0;
        idle();
        fifo_set();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pop", fifo_pop, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 8'h00);
        chk("rst_status", status, 0);
        chk("rst_irq", irq, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Stream drain of A5,3C,7E then status set/clear/mask rows
        tv[0]  = mk(1, 8'hA5, 0, 0, 4'h0, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0);
        tv[1]  = mk(1, 8'h3C, 0, 0, 4'h0, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0);
        tv[2]  = mk(1, 8'h7E, 0, 0, 4'h0, 4'h0, 1, 0, 8'h00, 4'h0, 0, 1);
        tv[3]  = mk(0, 8'h00, 0, 0, 4'h0, 4'h0, 1, 1, 8'hA5, 4'h0, 0, 1);
        tv[4]  = mk(0, 8'h00, 0, 0, 4'h0, 4'h0, 1, 1, 8'h3C, 4'h0, 0, 1);
        tv[5]  = mk(0, 8'h00, 0, 0, 4'h0, 4'h0, 0, 1, 8'h7E, 4'h0, 0, 1);
        tv[6]  = mk(0, 8'h00, 0, 0, 4'h0, 4'h0, 0, 0, 8'h7E, 4'h0, 0, 0);
        tv[7]  = mk(0, 8'h00, 1, 0, 4'h0, 4'h1, 0, 0, 8'h7E, 4'h0, 0, 0);
        tv[8]  = mk(0, 8'h00, 1, 0, 4'h1, 4'h1, 0, 0, 8'h7E, 4'h1, 1, 0);
        tv[9]  = mk(0, 8'h00, 0, 0, 4'h1, 4'h1, 0, 0, 8'h7E, 4'h1, 1, 0);
        tv[10] = mk(0, 8'h00, 0, 1, 4'h0, 4'h1, 0, 0, 8'h7E, 4'h0, 0, 0);
        tv[11] = mk(0, 8'h00, 0, 0, 4'h0, 4'h2, 0, 0, 8'h7E, 4'h2, 1, 0);
        tv[12] = mk(0, 8'h00, 0, 0, 4'h2, 4'h2, 0, 0, 8'h7E, 4'h2, 1, 0);
        tv[13] = mk(0, 8'h00, 0, 0, 4'h0, 4'h2, 0, 0, 8'h7E, 4'h0, 0, 0);

        for (int i = 0; i < 14; i++) begin
            rx_stb = tv[i].stb; rx_byte = tv[i].b;
            fifo_overrun = tv[i].ovr; fifo_underrun = tv[i].und;
            status_clr = tv[i].clr; irq_mask = tv[i].mask;
            mid();
            chk($sformatf("tv%0d_pop", i), fifo_pop, tv[i].pop);
            chk($sformatf("tv%0d_valid", i), m_valid, tv[i].vld);
            chk($sformatf("tv%0d_data", i), m_data, tv[i].dat);
            chk($sformatf("tv%0d_status", i), status, tv[i].st);
            chk($sformatf("tv%0d_irq", i), irq, tv[i].irq);
            chk($sformatf("tv%0d_busy", i), busy, tv[i].bsy);
            tick();
        end

        // Burst mode, threshold trigger on the 4th byte
        mode = 1'b1; irq_mask = 4'h8;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) push(8'(8'h11 * (i + 1)));
            mid();
            chk("thr_nopop", fifo_pop, 0);
            tick();
        end
        push(8'h44);
        mid();
        chk("thr_nopop4", fifo_pop, 0);
        tick();
        npop = 0;
        got.delete();
        for (int i = 0; i < 12; i++) begin
            mid();
            if (fifo_pop) npop++;
            if (m_valid && m_ready) got.push_back(m_data);
            tick();
        end
        chk("thr_npop", npop, 4);
        chk("thr_nbytes", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++)
            chk($sformatf("thr_byte%0d", i), got[i], 8'(8'h11 * (i + 1)));
        chk("thr_status", status, 4'h8);
        chk("thr_irq", irq, 1);
        chk("thr_busy", busy, 0);
        status_clr = 4'h8;
        tick();
        mid();
        chk("thr_clr_status", status, 0);
        chk("thr_clr_irq", irq, 0);
        tick();

        // Burst mode, character timeout (TIMEOUT = 8)
        irq_mask = 4'h4;
        push(8'h5A);
        mid();
        chk("tmo_pop0", fifo_pop, 0);
        tick();
        for (int k = 1; k <= 9; k++) begin
            mid();
            chk($sformatf("tmo_wait%0d", k), fifo_pop, 0);
            chk($sformatf("tmo_st%0d", k), status[2], 0);
            tick();
        end
        mid();
        chk("tmo_pop", fifo_pop, 1);
        chk("tmo_status", status[2], 1);
        chk("tmo_irq", irq, 1);
        tick();
        mid();
        chk("tmo_valid", m_valid, 1);
        chk("tmo_data", m_data, 8'h5A);
        tick();
        status_clr = 4'hF;
        tick();

        // Backpressure in stream mode
        mode = 1'b0; irq_mask = 4'h0; m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(8'(8'hB1 + i));
            mid();
            if (i == 2) chk("bp_firstpop", fifo_pop, 1);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            mid();
            chk("bp_valid", m_valid, 1);
            chk("bp_data", m_data, 8'hB1);
            chk("bp_pop", fifo_pop, 0);
            tick();
        end
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk($sformatf("bp_out%0d_valid", i), m_valid, 1);
            chk($sformatf("bp_out%0d_data", i), m_data, 8'(8'hB1 + i));
            chk($sformatf("bp_out%0d_pop", i), fifo_pop, (i < 2) ? 1 : 0);
            tick();
        end
        mid();
        chk("bp_done_valid", m_valid, 0);
        chk("bp_done_busy", busy, 0);
        tick();

        // Flush with a held byte and 6 FIFO entries
        m_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            push(8'(8'hC0 + i));
            mid();
            tick();
        end
        flush = 1'b1;
        mid();
        chk("fl_held", m_valid, 1);
        chk("fl_pop0", fifo_pop, 0);
        tick();
        for (int i = 0; i < 6; i++) begin
            mid();
            chk($sformatf("fl_pop%0d", i + 1), fifo_pop, 1);
            chk($sformatf("fl_valid%0d", i + 1), m_valid, 0);
            chk($sformatf("fl_busy%0d", i + 1), busy, 1);
            tick();
        end
        mid();
        chk("fl_empty_pop", fifo_pop, 0);
        chk("fl_fifo_empty", fifo_empty, 1);
        tick();
        mid();
        chk("fl_wait_busy", busy, 0);
        chk("fl_wait_valid", m_valid, 0);
        tick();

        // Asynchronous reset mid-DRAIN
        status_clr = 4'hF;
        tick();
        irq_mask = 4'hF;
        for (int i = 0; i < 3; i++) begin
            if (i < 2) push(8'(8'hD1 + i));
            mid();
            tick();
        end
        mid();
        chk("rd_valid_pre", m_valid, 1);
        chk("rd_busy_pre", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("rd_valid", m_valid, 0);
        chk("rd_data", m_data, 8'h00);
        chk("rd_busy", busy, 0);
        chk("rd_pop", fifo_pop, 0);
        chk("rd_status", status, 0);
        chk("rd_irq", irq, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        fifo_set();
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
